wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_arbiter_if.sv | 39 +++
 rtl/wb_fifo.sv | 45 ++++
 rtl/wb_arbiter.sv | 82 ++++++++
 tb/tb_wb_arbiter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the GPR write-port arbiter: buffer geometry, source encodings
// and the layout of one buffered late-result entry.
package wb_arbiter_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 2;
    localparam int PTR_W     = 1;
    localparam int WAIT_W    = 4;

    localparam logic SRC_W = 1'b0;
    localparam logic SRC_X = 1'b1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Register-file write-port bundle between the pipeline/late-result unit and the arbiter.
// The arbiter takes the slave modport; the pipeline side takes the master modport.
interface wb_arbiter_if;

    logic        W_RegWrite;
    logic [4:0]  W_RegAddr;
    logic [31:0] W_RegData;

    logic        X_Valid;
    logic        X_Ready;
    logic [4:0]  X_RegAddr;
    logic [31:0] X_RegData;

    logic        RF_WE;
    logic [4:0]  RF_Addr;
    logic [31:0] RF_WD;
    logic        RF_Src;

    logic        Stall_Req;
    logic [1:0]  Pend_Valid;
    logic [9:0]  Pend_Addr;

    modport slave (
        input  W_RegWrite, W_RegAddr, W_RegData,
        input  X_Valid, X_RegAddr, X_RegData,
        output X_Ready,
        output RF_WE, RF_Addr, RF_WD, RF_Src,
        output Stall_Req, Pend_Valid, Pend_Addr
    );

    modport master (
        output W_RegWrite, W_RegAddr, W_RegData,
        output X_Valid, X_RegAddr, X_RegData,
        input  X_Ready,
        input  RF_WE, RF_Addr, RF_WD, RF_Src,
        input  Stall_Req, Pend_Valid, Pend_Addr
    );

endinterface

// File: rtl/wb_fifo.sv
// Two-entry buffer of late results; head and second-entry address visible from registers.
// Caller must not push when full nor pop when empty; push and pop may coincide.
module wb_fifo
    import wb_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wb_entry_t        push_dat,
    input  logic             pop,
    output wb_entry_t        head_dat,
    output logic [4:0]       next_addr,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] nxt_ptr;
    wb_entry_t        mem [BUF_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign nxt_ptr   = rd_ptr + 1'b1;
    assign head_dat  = mem[rd_ptr];
    assign next_addr = mem[nxt_ptr].addr;

endmodule

// File: rtl/wb_arbiter.sv
// Single-write-port arbiter: W stage always wins, buffered late results drain in idle cycles.
// Late results wait at least one cycle; a stall is requested after STARVE_LIMIT blocked cycles.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STARVE_LIMIT);

    logic             w_eff;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    wb_entry_t        head_dat;
    wb_entry_t        push_dat;
    logic [4:0]       next_addr;
    logic [WAIT_W-1:0] wait_cnt;

    assign w_eff = bus.W_RegWrite && (bus.W_RegAddr != 5'd0);
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(BUF_DEPTH));

    // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
    assign bus.X_Ready = reset && !full;

    assign push          = bus.X_Valid && bus.X_Ready && (bus.X_RegAddr != 5'd0);
    assign pop           = reset && !w_eff && !empty;
    assign push_dat.addr = bus.X_RegAddr;
    assign push_dat.data = bus.X_RegData;

    wb_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_dat  (push_dat),
        .pop       (pop),
        .head_dat  (head_dat),
        .next_addr (next_addr),
        .count     (count)
    );

    always_comb begin
        bus.RF_WE   = 1'b0;
        bus.RF_Addr = 5'd0;
        bus.RF_WD   = 32'd0;
        bus.RF_Src  = SRC_W;
        if (reset) begin
            if (w_eff) begin
                bus.RF_WE   = 1'b1;
                bus.RF_Addr = bus.W_RegAddr;
                bus.RF_WD   = bus.W_RegData;
            end else if (!empty) begin
                bus.RF_WE   = 1'b1;
                bus.RF_Addr = head_dat.addr;
                bus.RF_WD   = head_dat.data;
                bus.RF_Src  = SRC_X;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (empty || pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign bus.Stall_Req  = (wait_cnt == WAIT_LIMIT);
    assign bus.Pend_Valid = {full, !empty};
    assign bus.Pend_Addr  = {full ? next_addr : 5'd0, empty ? 5'd0 : head_dat.addr};

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, drain, starvation stall, $0 filtering, full-buffer
// backpressure and asynchronous reset with pending entries.
module tb_wb_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                         input logic xv, input logic [4:0] xa, input logic [31:0] xd);
        bus.W_RegWrite = wwe;
        bus.W_RegAddr  = wa;
        bus.W_RegData  = wd;
        bus.X_Valid    = xv;
        bus.X_RegAddr  = xa;
        bus.X_RegData  = xd;
        #1;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] a,
                          input logic [31:0] d, input logic src);
        chk({tag, ".we"},   bus.RF_WE,   we);
        chk({tag, ".addr"}, bus.RF_Addr, a);
        chk({tag, ".wd"},   bus.RF_WD,   d);
        chk({tag, ".src"},  bus.RF_Src,  src);
    endtask

    initial begin
        // reset held with an active W request
        drive(1'b1, 5'd8, 32'h12345678, 1'b0, 5'd0, 32'd0);
        chk_rf("rst", 1'b0, 5'd0, 32'd0, 1'b0);
        chk("rst.xrdy",  bus.X_Ready,    1'b0);
        chk("rst.stall", bus.Stall_Req,  1'b0);
        chk("rst.pend",  bus.Pend_Valid, 2'b00);
        step();
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        #1;
        chk("rel.xrdy", bus.X_Ready, 1'b1);
        chk_rf("rel", 1'b0, 5'd0, 32'd0, 1'b0);

        // single late result drains the cycle after acceptance
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11111111);
        chk("x5.nobypass", bus.RF_WE, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_rf("x5.drain", 1'b1, 5'd5, 32'h11111111, 1'b1);
        chk("x5.pend", bus.Pend_Valid, 2'b01);
        step();
        chk("x5.pend0", bus.Pend_Valid, 2'b00);
        chk_rf("x5.idle", 1'b0, 5'd0, 32'd0, 1'b0);

        // late result to $0 is discarded
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCAFE0000);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("x0.pend", bus.Pend_Valid, 2'b00);
        chk("x0.we",   bus.RF_WE,      1'b0);
        chk("x0.xrdy", bus.X_Ready,    1'b1);

        // starvation under continuous W writes
        step();
        drive(1'b1, 5'd8, 32'hAAAA0000, 1'b1, 5'd3, 32'h3);
        chk_rf("st.c0", 1'b1, 5'd8, 32'hAAAA0000, 1'b0);
        step();
        drive(1'b1, 5'd8, 32'hAAAA0000, 1'b1, 5'd4, 32'h4);
        chk("st.c1.xrdy", bus.X_Ready, 1'b1);
        step();
        drive(1'b1, 5'd8, 32'hAAAA0000, 1'b0, 5'd0, 32'd0);
        chk("st.c2.xrdy",  bus.X_Ready,    1'b0);
        chk("st.c2.pend",  bus.Pend_Valid, 2'b11);
        chk("st.c2.paddr", bus.Pend_Addr,  10'h083);
        chk("st.c2.stall", bus.Stall_Req,  1'b0);
        step();
        step();
        chk("st.c4.stall", bus.Stall_Req, 1'b0);
        chk("st.c4.src",   bus.RF_Src,    1'b0);
        step();
        chk("st.c5.stall", bus.Stall_Req, 1'b1);
        chk("st.c5.src",   bus.RF_Src,    1'b0);
        step();
        chk("st.c6.stall", bus.Stall_Req, 1'b1);
        drive(1'b0, 5'd8, 32'hAAAA0000, 1'b0, 5'd0, 32'd0);
        chk_rf("st.c6", 1'b1, 5'd3, 32'h3, 1'b1);
        step();
        chk_rf("st.c7", 1'b1, 5'd4, 32'h4, 1'b1);
        chk("st.c7.stall", bus.Stall_Req, 1'b0);
        chk("st.c7.xrdy",  bus.X_Ready,   1'b1);
        step();
        chk("st.c8.pend", bus.Pend_Valid, 2'b00);
        chk("st.c8.we",   bus.RF_WE,      1'b0);

        // W write to $0 does not block the buffer
        drive(1'b1, 5'd8, 32'h88888888, 1'b1, 5'd7, 32'h77);
        step();
        drive(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk_rf("w0", 1'b1, 5'd7, 32'h77, 1'b1);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("w0.after", bus.RF_WE, 1'b0);

        // full buffer: pop does not free a slot until the next cycle
        drive(1'b1, 5'd8, 32'h8, 1'b1, 5'd1, 32'h1);
        step();
        drive(1'b1, 5'd8, 32'h8, 1'b1, 5'd2, 32'h2);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9);
        chk("bp.c2.xrdy", bus.X_Ready, 1'b0);
        chk_rf("bp.c2", 1'b1, 5'd1, 32'h1, 1'b1);
        step();
        chk("bp.c3.xrdy", bus.X_Ready, 1'b1);
        chk_rf("bp.c3", 1'b1, 5'd2, 32'h2, 1'b1);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_rf("bp.c4", 1'b1, 5'd9, 32'h9, 1'b1);
        chk("bp.c4.pend", bus.Pend_Valid, 2'b01);
        step();
        chk("bp.c5.we", bus.RF_WE, 1'b0);

        // asynchronous reset with two entries pending
        drive(1'b1, 5'd8, 32'h8, 1'b1, 5'd10, 32'hA);
        step();
        drive(1'b1, 5'd8, 32'h8, 1'b1, 5'd11, 32'hB);
        step();
        drive(1'b1, 5'd8, 32'h8, 1'b0, 5'd0, 32'd0);
        chk("ar.pend", bus.Pend_Valid, 2'b11);
        reset = 1'b0;
        #1;
        chk("ar.we",    bus.RF_WE,      1'b0);
        chk("ar.pend0", bus.Pend_Valid, 2'b00);
        chk("ar.xrdy",  bus.X_Ready,    1'b0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        #1;
        chk("ar.rel.we",   bus.RF_WE,      1'b0);
        chk("ar.rel.pend", bus.Pend_Valid, 2'b00);
        chk("ar.rel.xrdy", bus.X_Ready,    1'b1);
        step();
        chk("ar.post.we", bus.RF_WE, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
